// File: rtl/datapath_ctrl_pkg.sv
// Shared types and instruction-field constants for the datapath controller.
package datapath_ctrl_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OPC_W   = 3;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned REG_W   = 3;
    localparam int unsigned SH_W    = 2;
    localparam int unsigned ALU_W   = 2;

    localparam int unsigned OPC_LSB = 13;
    localparam int unsigned OP_LSB  = 11;
    localparam int unsigned RN_LSB  = 8;
    localparam int unsigned RD_LSB  = 5;
    localparam int unsigned SH_LSB  = 3;
    localparam int unsigned RM_LSB  = 0;

    localparam logic [OPC_W-1:0] OPC_MOV = 3'b110;
    localparam logic [OPC_W-1:0] OPC_ALU = 3'b101;
    localparam logic [OP_W-1:0]  OP_MOVI = 2'b10;
    localparam logic [OP_W-1:0]  OP_MOVR = 2'b00;
    localparam logic [OP_W-1:0]  OP_ADD  = 2'b00;
    localparam logic [OP_W-1:0]  OP_CMP  = 2'b01;
    localparam logic [OP_W-1:0]  OP_AND  = 2'b10;
    localparam logic [OP_W-1:0]  OP_MVN  = 2'b11;

    localparam logic [ALU_W-1:0] ALU_ADD = 2'b00;
    localparam logic [ALU_W-1:0] ALU_SUB = 2'b01;
    localparam logic [ALU_W-1:0] ALU_AND = 2'b10;
    localparam logic [ALU_W-1:0] ALU_NOT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_GETA, S_GETB, S_EXEC, S_WREG, S_WIMM
    } state_t;

    typedef enum logic [2:0] {
        CLS_MOVI, CLS_MOVR, CLS_ADD, CLS_CMP, CLS_AND, CLS_MVN, CLS_ILL
    } cls_t;

    typedef struct packed {
        cls_t             cls;
        logic [REG_W-1:0] rn;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rm;
        logic [SH_W-1:0]  sh;
        logic [ALU_W-1:0] aluop;
    } dec_t;

endpackage

// File: rtl/datapath_ctrl_decode.sv
// Combinational instruction decode: IR -> class, register fields, ALU op, sign-extended immediate.
module ctrl_decode
    import datapath_ctrl_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned IMM_W = 8
) (
    input  logic [INSTR_W-1:0] ir,
    output dec_t               dec,
    output logic [W-1:0]       sximm
);

    logic [OPC_W-1:0] opc;
    logic [OP_W-1:0]  op;

    assign opc = ir[OPC_LSB +: OPC_W];
    assign op  = ir[OP_LSB  +: OP_W];

    always_comb begin
        dec       = '0;
        dec.cls   = CLS_ILL;
        dec.rn    = ir[RN_LSB +: REG_W];
        dec.rd    = ir[RD_LSB +: REG_W];
        dec.rm    = ir[RM_LSB +: REG_W];
        dec.sh    = ir[SH_LSB +: SH_W];
        dec.aluop = ALU_W'(op);
        if (opc == OPC_MOV && op == OP_MOVI) begin
            dec.cls = CLS_MOVI;
        end else if (opc == OPC_MOV && op == OP_MOVR) begin
            dec.cls   = CLS_MOVR;
            dec.aluop = ALU_ADD;
        end else if (opc == OPC_ALU) begin
            case (op)
                OP_ADD:  dec.cls = CLS_ADD;
                OP_CMP:  dec.cls = CLS_CMP;
                OP_AND:  dec.cls = CLS_AND;
                default: dec.cls = CLS_MVN;
            endcase
        end
    end

    assign sximm = W'($signed(ir[IMM_W-1:0]));

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle Moore controller sequencing register read, ALU execute and write-back.
module datapath_ctrl
    import datapath_ctrl_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned IMM_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [INSTR_W-1:0] instr,
    output logic               w,
    output logic               illegal,
    output logic [REG_W-1:0]   readnum,
    output logic [REG_W-1:0]   writenum,
    output logic               write,
    output logic               vsel,
    output logic [W-1:0]       datapath_in,
    output logic               loada,
    output logic               loadb,
    output logic               asel,
    output logic               bsel,
    output logic [SH_W-1:0]    shift,
    output logic [ALU_W-1:0]   ALUop,
    output logic               loadc,
    output logic               loads
);

    state_t             state, state_nxt;
    logic [INSTR_W-1:0] ir;
    dec_t               dec;
    logic [W-1:0]       sximm;

    ctrl_decode #(.W(W), .IMM_W(IMM_W)) u_decode (
        .ir    (ir),
        .dec   (dec),
        .sximm (sximm)
    );

    // State and IR; instr is only captured on an accepted start in IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) ir <= instr;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_DECODE;
            S_DECODE: begin
                case (dec.cls)
                    CLS_MOVI:                 state_nxt = S_WIMM;
                    CLS_MOVR, CLS_MVN:        state_nxt = S_GETB;
                    CLS_ADD, CLS_CMP, CLS_AND: state_nxt = S_GETA;
                    default:                  state_nxt = S_IDLE;
                endcase
            end
            S_GETA:   state_nxt = S_GETB;
            S_GETB:   state_nxt = S_EXEC;
            S_EXEC:   state_nxt = (dec.cls == CLS_CMP) ? S_IDLE : S_WREG;
            S_WREG:   state_nxt = S_IDLE;
            S_WIMM:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w           = 1'b0;
        illegal     = 1'b0;
        readnum     = '0;
        writenum    = '0;
        write       = 1'b0;
        vsel        = 1'b0;
        datapath_in = sximm;
        loada       = 1'b0;
        loadb       = 1'b0;
        asel        = 1'b0;
        bsel        = 1'b0;
        shift       = '0;
        ALUop       = '0;
        loadc       = 1'b0;
        loads       = 1'b0;
        case (state)
            S_IDLE:   w = 1'b1;
            S_DECODE: illegal = (dec.cls == CLS_ILL);
            S_GETA: begin
                readnum = dec.rn;
                loada   = 1'b1;
            end
            S_GETB: begin
                readnum = dec.rm;
                loadb   = 1'b1;
            end
            S_EXEC: begin
                shift = dec.sh;
                asel  = (dec.cls == CLS_MOVR) || (dec.cls == CLS_MVN);
                ALUop = dec.aluop;
                if (dec.cls == CLS_CMP) loads = 1'b1;
                else                    loadc = 1'b1;
            end
            S_WREG: begin
                writenum = dec.rd;
                write    = 1'b1;
            end
            S_WIMM: begin
                writenum = dec.rn;
                vsel     = 1'b1;
                write    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
